// File: rtl/display_spi_pkg.sv
// Shared definitions for the display SPI link: command code, frame width,
// display register map and the master FSM state encoding.
package display_spi_pkg;

    localparam logic [3:0] CMD_WRITE   = 4'b0001;
    localparam int         FRAME_WIDTH = 16;

    localparam logic [3:0] REG_ENABLE = 4'd0;
    localparam logic [3:0] REG_DIGIT1 = 4'd1;
    localparam logic [3:0] REG_DIGIT2 = 4'd2;
    localparam logic [3:0] REG_DIGIT3 = 4'd3;
    localparam logic [3:0] REG_DIGIT4 = 4'd4;
    localparam logic [3:0] REG_DIGIT5 = 4'd5;
    localparam logic [3:0] REG_DIGIT6 = 4'd6;
    localparam logic [3:0] REG_DIGIT7 = 4'd7;
    localparam logic [3:0] REG_DIGIT8 = 4'd8;
    localparam logic [3:0] REG_RADIX  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_GAP  = 3'd4
    } spi_state_e;

    // Builds the on-wire frame for a register write.
    function automatic logic [FRAME_WIDTH-1:0] make_frame(input logic [3:0] addr,
                                                          input logic [7:0] data);
        return {CMD_WRITE, addr, data};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-based full/empty flags and a
// first-word-fall-through read port. DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage array; data only, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/display_spi_master.sv
// SPI master that turns queued display-register writes into 16-bit frames.
// SCLK idles high; the slave samples MOSI on SCLK rising edges while SS is low.
// All pin outputs are registered decodes of the current state, so every pin
// lags the state by one clock and never glitches. CLK_DIV >= 2, GAP_CYCLES >= 4.
module display_spi_master
    import display_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       block_clk_i,
    input  logic       rst_low_i,
    input  logic       wr_valid_i,
    input  logic [3:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    output logic       wr_ready_o,
    output logic       spi_sclk_o,
    output logic       spi_ss_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       busy_o,
    output logic       frame_done_o
);
    localparam int               CNT_MAX   = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int               CNT_W     = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    spi_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [3:0]             r_bitcnt;
    logic [FRAME_WIDTH-1:0] r_shreg;
    logic                   r_sclk;
    logic                   r_ss;
    logic                   r_mosi;
    logic                   r_frame_done;

    logic [11:0] w_fifo_dout;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_half_done;
    logic        w_gap_done;
    logic        w_shift;
    logic        w_unused;

    // MISO exists only for the pin-out.
    assign w_unused = spi_miso_i;

    assign w_push      = wr_valid_i && wr_ready_o;
    assign w_pop       = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_half_done = (r_cnt == HALF_LAST);
    assign w_gap_done  = (r_cnt == GAP_LAST);
    assign w_shift     = (r_state == ST_HIGH) && w_half_done && (r_bitcnt != 4'd15);

    assign wr_ready_o   = !w_fifo_full;
    assign busy_o       = (r_state != ST_IDLE) || !w_fifo_empty;
    assign spi_sclk_o   = r_sclk;
    assign spi_ss_o     = r_ss;
    assign spi_mosi_o   = r_mosi;
    assign frame_done_o = r_frame_done;

    sync_fifo #(
        .WIDTH(12),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (block_clk_i),
        .i_rst_n(rst_low_i),
        .i_push (w_push),
        .i_data ({wr_addr_i, wr_data_i}),
        .i_pop  (w_pop),
        .o_data (w_fifo_dout),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    // Frame shift register: loaded on pop, shifted left at the end of each non-final HIGH.
    always_ff @(posedge block_clk_i) begin
        if (w_pop) begin
            r_shreg <= make_frame(w_fifo_dout[11:8], w_fifo_dout[7:0]);
        end else if (w_shift) begin
            r_shreg <= {r_shreg[FRAME_WIDTH-2:0], 1'b0};
        end
    end

    // Frame sequencer with registered pin outputs decoded from the current state.
    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bitcnt     <= '0;
            r_sclk       <= 1'b1;
            r_ss         <= 1'b1;
            r_mosi       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            // SCLK drops during LEAD so it is already low when SS falls, and
            // SS rises at the start of GAP while SCLK is still high.
            r_sclk       <= !((r_state == ST_LEAD) || (r_state == ST_LOW));
            r_ss         <= !((r_state == ST_LOW) || (r_state == ST_HIGH));
            r_mosi       <= ((r_state == ST_LOW) || (r_state == ST_HIGH)) ?
                            r_shreg[FRAME_WIDTH-1] : 1'b1;
            r_frame_done <= (r_state == ST_GAP) && (r_cnt == '0);

            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_bitcnt <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (w_half_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_LOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_half_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_half_done) begin
                        r_cnt <= '0;
                        if (r_bitcnt == 4'd15) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_state  <= ST_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_gap_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
